// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_ctrl_pkg
//  Description : Shared types and encodings for the multicycle MIPS control
//                FSM: state enum, opcode values, datapath select encodings
//                and the bundled control-output struct.
//  Options     : MC_CTRL_EXC_EN (consumed by the users of this package)
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

  // One state per micro-step of an instruction.
  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_RWB    = 4'd4,
    S_MADDR  = 4'd5,
    S_MRD    = 4'd6,
    S_MWB    = 4'd7,
    S_MWR    = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_JAL    = 4'd11,
    S_ADDI   = 4'd12,
    S_IWB    = 4'd13,
    S_LUI    = 4'd14,
    S_EXC    = 4'd15
  } state_t;

  // Opcodes (IR[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  // Register destination select.
  localparam logic [1:0] RD_RT  = 2'd0;
  localparam logic [1:0] RD_RD  = 2'd1;
  localparam logic [1:0] RD_R31 = 2'd2;

  // ALU operand B select.
  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  // ALU operation.
  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;
  localparam logic [1:0] ALU_LUI   = 2'd3;

  // PC source select.
  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_EXC    = 2'd3;

  // Writeback mux select; codes 4-7 are reserved and never driven.
  localparam logic [2:0] WB_ALUOUT = 3'd0;
  localparam logic [2:0] WB_MDR    = 3'd1;
  localparam logic [2:0] WB_PC     = 3'd2;
  localparam logic [2:0] WB_LUI    = 3'd3;

  // Every datapath control produced by the output decoder.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic [2:0] wb_sel;
    logic       exc_illegal;
  } ctrl_t;

  // True for every opcode the decoder dispatches to a real instruction path.
  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL, OP_ADDI, OP_LUI:
        is_legal_op = 1'b1;
      default:
        is_legal_op = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_ctrl_outdec.sv
`default_nettype none
// ============================================================================
//  Module      : mips_ctrl_outdec
//  Description : Moore output decoder for the multicycle MIPS control FSM.
//                Only the fetch-stage PC/IR loads look at mem_ready so the
//                IR and PC update on the same edge the fetch completes.
//  Options     : MC_CTRL_EXC_EN enables the illegal-opcode exception state.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t i_state,
  input  logic   i_mem_ready,
  output ctrl_t  o_ctrl
);

  // Decode the control word from the current state; everything idles at 0.
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.iord      = 1'b0;
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_a = 1'b0;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALU_ADD;
        o_ctrl.pc_source = PC_ALU;
        o_ctrl.pc_write  = i_mem_ready;
        o_ctrl.ir_write  = i_mem_ready;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut.
        o_ctrl.alu_src_a = 1'b0;
        o_ctrl.alu_src_b = SRCB_IMM_SH;
        o_ctrl.alu_op    = ALU_ADD;
      end
      S_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_B;
        o_ctrl.alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = RD_RD;
        o_ctrl.wb_sel    = WB_ALUOUT;
      end
      S_MADDR, S_ADDI: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALU_ADD;
      end
      S_MRD: begin
        o_ctrl.iord     = 1'b1;
        o_ctrl.mem_read = 1'b1;
      end
      S_MWB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = RD_RT;
        o_ctrl.wb_sel    = WB_MDR;
      end
      S_MWR: begin
        o_ctrl.iord      = 1'b1;
        o_ctrl.mem_write = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_B;
        o_ctrl.alu_op        = ALU_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PC_ALUOUT;
      end
      S_JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PC_JUMP;
      end
      S_JAL: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PC_JUMP;
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = RD_R31;
        o_ctrl.wb_sel    = WB_PC;
      end
      S_IWB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = RD_RT;
        o_ctrl.wb_sel    = WB_ALUOUT;
      end
      S_LUI: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = RD_RT;
        o_ctrl.wb_sel    = WB_LUI;
        o_ctrl.alu_op    = ALU_LUI;
      end
`ifdef MC_CTRL_EXC_EN
      S_EXC: begin
        o_ctrl.exc_illegal = 1'b1;
        o_ctrl.pc_write    = 1'b1;
        o_ctrl.pc_source   = PC_EXC;
      end
`endif
      default: begin
        o_ctrl = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips_mc_control.sv
`default_nettype none
// ============================================================================
//  Module      : mips_mc_control
//  Description : Multicycle MIPS control FSM. Holds the state register, the
//                next-state logic and the retired-instruction counter; the
//                datapath controls come from mips_ctrl_outdec.
//  Options     : MC_CTRL_EXC_EN - illegal opcodes trap through S_EXC instead
//                of retiring as a NOP.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_mc_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       i_opcode,
  input  logic             i_zero,
  input  logic             i_mem_ready,
  output logic             o_pc_write,
  output logic             o_pc_write_cond,
  output logic             o_iord,
  output logic             o_mem_read,
  output logic             o_mem_write,
  output logic             o_ir_write,
  output logic             o_reg_write,
  output logic [1:0]       o_reg_dst,
  output logic             o_alu_src_a,
  output logic [1:0]       o_alu_src_b,
  output logic [1:0]       o_alu_op,
  output logic [1:0]       o_pc_source,
  output logic [2:0]       o_wb_sel,
  output logic             o_instr_done,
  output logic [CNT_W-1:0] o_instr_count,
  output logic             o_exc_illegal
);

  state_t            r_state;
  state_t            w_state_next;
  logic              w_retire;
  logic              r_is_lw;
  logic [CNT_W-1:0]  r_count;
  ctrl_t             w_ctrl;

  // The zero flag is applied by the datapath through pc_write_cond; the
  // controller itself never branches on it.
  logic              w_zero_unused;
  assign w_zero_unused = i_zero;

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and retirement detect.
  always_comb begin
    w_state_next = r_state;
    w_retire     = 1'b0;
    case (r_state)
      S_INIT: begin
        w_state_next = S_FETCH;
      end
      S_FETCH: begin
        if (i_mem_ready) begin
          w_state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        case (i_opcode)
          OP_RTYPE:     w_state_next = S_EXEC;
          OP_LW, OP_SW: w_state_next = S_MADDR;
          OP_BEQ:       w_state_next = S_BRANCH;
          OP_J:         w_state_next = S_JUMP;
          OP_JAL:       w_state_next = S_JAL;
          OP_ADDI:      w_state_next = S_ADDI;
          OP_LUI:       w_state_next = S_LUI;
          default: begin
`ifdef MC_CTRL_EXC_EN
            w_state_next = S_EXC;
`else
            // Unknown opcodes behave as a NOP and still retire.
            w_state_next = S_FETCH;
            w_retire     = !is_legal_op(i_opcode);
`endif
          end
        endcase
      end
      S_EXEC: begin
        w_state_next = S_RWB;
      end
      S_MADDR: begin
        w_state_next = r_is_lw ? S_MRD : S_MWR;
      end
      S_MRD: begin
        if (i_mem_ready) begin
          w_state_next = S_MWB;
        end
      end
      S_MWR: begin
        if (i_mem_ready) begin
          w_state_next = S_FETCH;
          w_retire     = 1'b1;
        end
      end
      S_ADDI: begin
        w_state_next = S_IWB;
      end
      S_RWB, S_MWB, S_IWB, S_BRANCH, S_JUMP, S_JAL, S_LUI: begin
        w_state_next = S_FETCH;
        w_retire     = 1'b1;
      end
      S_EXC: begin
        // Trap completes without counting as a retired instruction.
        w_state_next = S_FETCH;
      end
      default: begin
        w_state_next = S_INIT;
      end
    endcase
  end

  // Remember load vs store at decode, since the opcode is only valid there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_lw <= 1'b0;
    end else if (r_state == S_DECODE) begin
      r_is_lw <= (i_opcode == OP_LW);
    end
  end

  // Retired-instruction counter, wrapping silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_retire) begin
      r_count <= r_count + 1'b1;
    end
  end

  mips_ctrl_outdec u_outdec (
    .i_state     (r_state),
    .i_mem_ready (i_mem_ready),
    .o_ctrl      (w_ctrl)
  );

  assign o_pc_write      = w_ctrl.pc_write;
  assign o_pc_write_cond = w_ctrl.pc_write_cond;
  assign o_iord          = w_ctrl.iord;
  assign o_mem_read      = w_ctrl.mem_read;
  assign o_mem_write     = w_ctrl.mem_write;
  assign o_ir_write      = w_ctrl.ir_write;
  assign o_reg_write     = w_ctrl.reg_write;
  assign o_reg_dst       = w_ctrl.reg_dst;
  assign o_alu_src_a     = w_ctrl.alu_src_a;
  assign o_alu_src_b     = w_ctrl.alu_src_b;
  assign o_alu_op        = w_ctrl.alu_op;
  assign o_pc_source     = w_ctrl.pc_source;
  assign o_wb_sel        = w_ctrl.wb_sel;
  assign o_exc_illegal   = w_ctrl.exc_illegal;
  assign o_instr_done    = w_retire;
  assign o_instr_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_mc_control
//  Description : Self-checking bench for mips_mc_control. Each instruction
//                is expanded into its expected per-cycle control words from
//                the instruction class and the memory stall counts.
//  Options     : MC_CTRL_EXC_EN (must match the RTL build)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_mc_control;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [5:0]       i_opcode;
  logic             i_zero;
  logic             i_mem_ready;
  logic             o_pc_write, o_pc_write_cond, o_iord, o_mem_read, o_mem_write;
  logic             o_ir_write, o_reg_write, o_alu_src_a, o_instr_done, o_exc_illegal;
  logic [1:0]       o_reg_dst, o_alu_src_b, o_alu_op, o_pc_source;
  logic [2:0]       o_wb_sel;
  logic [CNT_W-1:0] o_instr_count;

  int checks   = 0;
  int failures = 0;
  int m_cnt    = 0;

  mips_mc_control #(.CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_opcode        (i_opcode),
    .i_zero          (i_zero),
    .i_mem_ready     (i_mem_ready),
    .o_pc_write      (o_pc_write),
    .o_pc_write_cond (o_pc_write_cond),
    .o_iord          (o_iord),
    .o_mem_read      (o_mem_read),
    .o_mem_write     (o_mem_write),
    .o_ir_write      (o_ir_write),
    .o_reg_write     (o_reg_write),
    .o_reg_dst       (o_reg_dst),
    .o_alu_src_a     (o_alu_src_a),
    .o_alu_src_b     (o_alu_src_b),
    .o_alu_op        (o_alu_op),
    .o_pc_source     (o_pc_source),
    .o_wb_sel        (o_wb_sel),
    .o_instr_done    (o_instr_done),
    .o_instr_count   (o_instr_count),
    .o_exc_illegal   (o_exc_illegal)
  );

  always #5 clk = ~clk;

  logic [20:0] w_obs;
  assign w_obs = {o_exc_illegal, o_pc_write, o_pc_write_cond, o_iord, o_mem_read,
                  o_mem_write, o_ir_write, o_reg_write, o_reg_dst, o_alu_src_a,
                  o_alu_src_b, o_alu_op, o_pc_source, o_wb_sel, o_instr_done};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pack an expected control word in the same field order as w_obs.
  function automatic logic [20:0] mk(input int exc, input int pcw, input int pcwc,
                                     input int iord, input int mr, input int mw,
                                     input int irw, input int rw, input int rdst,
                                     input int sa, input int sb, input int aop,
                                     input int psrc, input int wb, input int done);
    return {1'(exc), 1'(pcw), 1'(pcwc), 1'(iord), 1'(mr), 1'(mw), 1'(irw),
            1'(rw), 2'(rdst), 1'(sa), 2'(sb), 2'(aop), 2'(psrc), 3'(wb), 1'(done)};
  endfunction

  // One clock: drive inputs at the falling edge, compare, then advance model.
  task automatic cycle(input string tag, input logic [20:0] exp, input logic mr,
                       input logic [5:0] op);
    @(negedge clk);
    i_mem_ready = mr;
    i_opcode    = op;
    i_zero      = 1'($urandom);
    #1;
    check(tag, 32'(w_obs), 32'(exp));
    check({tag, "_cnt"}, 32'(o_instr_count), 32'(m_cnt));
    if (exp[0]) m_cnt = (m_cnt + 1) % (1 << CNT_W);
  endtask

  function automatic bit legal(input logic [5:0] op);
    return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 ||
           op == 6'h02 || op == 6'h03 || op == 6'h08 || op == 6'h0F;
  endfunction

  // Run one instruction with fst fetch stalls and mst data-memory stalls.
  task automatic run_instr(input logic [5:0] op, input int fst, input int mst);
    int dec_done;
    repeat (fst) cycle("fetch_wait", mk(0,0,0,0,1,0,0,0,0,0,1,0,0,0,0), 1'b0, 6'($urandom));
    cycle("fetch", mk(0,1,0,0,1,0,1,0,0,0,1,0,0,0,0), 1'b1, 6'($urandom));
`ifdef MC_CTRL_EXC_EN
    dec_done = 0;
`else
    dec_done = legal(op) ? 0 : 1;
`endif
    cycle("decode", mk(0,0,0,0,0,0,0,0,0,0,3,0,0,0,dec_done), 1'($urandom), op);
    case (op)
      6'h00: begin
        cycle("exec", mk(0,0,0,0,0,0,0,0,0,1,0,2,0,0,0), 1'($urandom), 6'($urandom));
        cycle("rwb",  mk(0,0,0,0,0,0,0,1,1,0,0,0,0,0,1), 1'($urandom), 6'($urandom));
      end
      6'h23: begin
        cycle("maddr", mk(0,0,0,0,0,0,0,0,0,1,2,0,0,0,0), 1'($urandom), 6'($urandom));
        repeat (mst) cycle("mrd_wait", mk(0,0,0,1,1,0,0,0,0,0,0,0,0,0,0), 1'b0, 6'($urandom));
        cycle("mrd", mk(0,0,0,1,1,0,0,0,0,0,0,0,0,0,0), 1'b1, 6'($urandom));
        cycle("mwb", mk(0,0,0,0,0,0,0,1,0,0,0,0,0,1,1), 1'($urandom), 6'($urandom));
      end
      6'h2B: begin
        cycle("maddr", mk(0,0,0,0,0,0,0,0,0,1,2,0,0,0,0), 1'($urandom), 6'($urandom));
        repeat (mst) cycle("mwr_wait", mk(0,0,0,1,0,1,0,0,0,0,0,0,0,0,0), 1'b0, 6'($urandom));
        cycle("mwr", mk(0,0,0,1,0,1,0,0,0,0,0,0,0,0,1), 1'b1, 6'($urandom));
      end
      6'h04: cycle("beq", mk(0,0,1,0,0,0,0,0,0,1,0,1,1,0,1), 1'($urandom), 6'($urandom));
      6'h02: cycle("j",   mk(0,1,0,0,0,0,0,0,0,0,0,0,2,0,1), 1'($urandom), 6'($urandom));
      6'h03: cycle("jal", mk(0,1,0,0,0,0,0,1,2,0,0,0,2,2,1), 1'($urandom), 6'($urandom));
      6'h08: begin
        cycle("addi", mk(0,0,0,0,0,0,0,0,0,1,2,0,0,0,0), 1'($urandom), 6'($urandom));
        cycle("iwb",  mk(0,0,0,0,0,0,0,1,0,0,0,0,0,0,1), 1'($urandom), 6'($urandom));
      end
      6'h0F: cycle("lui", mk(0,0,0,0,0,0,0,1,0,0,0,3,0,3,1), 1'($urandom), 6'($urandom));
      default: begin
`ifdef MC_CTRL_EXC_EN
        cycle("exc", mk(1,1,0,0,0,0,0,0,0,0,0,0,3,0,0), 1'($urandom), 6'($urandom));
`endif
      end
    endcase
  endtask

  // Release reset mid-cycle and confirm the idle S_INIT cycle.
  task automatic release_reset();
    rst_n = 1'b1;
    #1;
    check("init_after_release", 32'(w_obs), 32'd0);
    check("init_cnt", 32'(o_instr_count), 32'(m_cnt));
  endtask

  logic [5:0] op_tab [10];
  int         saved_cnt;

  initial begin
    op_tab = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03, 6'h08, 6'h0F, 6'h3F, 6'h15};
    rst_n       = 1'b0;
    i_opcode    = 6'h00;
    i_zero      = 1'b0;
    i_mem_ready = 1'b0;

    // Reset held three cycles: every output idle, count zero.
    repeat (3) cycle("reset", 21'd0, 1'($urandom), 6'($urandom));
    release_reset();

    // Directed: lw with two data stalls, then the short instructions.
    run_instr(6'h23, 0, 2);
    run_instr(6'h04, 1, 0);
    run_instr(6'h03, 0, 0);
    run_instr(6'h0F, 0, 0);
    run_instr(6'h3F, 0, 0);
    run_instr(6'h00, 2, 0);
    run_instr(6'h08, 0, 0);
    run_instr(6'h2B, 0, 1);
    run_instr(6'h02, 0, 0);

    // Random instruction mix with random stalls and unlisted opcodes.
    for (int i = 0; i < 80; i++) begin
      logic [5:0] op;
      op = op_tab[$urandom_range(0, 9)];
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // Make sure the count is nonzero before aborting a store.
    run_instr(6'h00, 0, 0);
    cycle("fetch", mk(0,1,0,0,1,0,1,0,0,0,1,0,0,0,0), 1'b1, 6'($urandom));
    cycle("decode", mk(0,0,0,0,0,0,0,0,0,0,3,0,0,0,0), 1'b0, 6'h2B);
    cycle("maddr", mk(0,0,0,0,0,0,0,0,0,1,2,0,0,0,0), 1'b0, 6'($urandom));
    cycle("mwr_wait", mk(0,0,0,1,0,1,0,0,0,0,0,0,0,0,0), 1'b0, 6'($urandom));
    rst_n = 1'b0;
    #1;
    check("mwr_async_mem_write", 32'(o_mem_write), 32'd0);
    check("mwr_async_outputs", 32'(w_obs), 32'd0);
    check("mwr_async_cnt", 32'(o_instr_count), 32'd0);
    m_cnt = 0;
    cycle("reset_hold", 21'd0, 1'b1, 6'($urandom));
    release_reset();

    // Sixteen R-types wrap the 4-bit counter back to its start value.
    saved_cnt = m_cnt;
    repeat (16) run_instr(6'h00, 0, 0);
    cycle("fetch_wait", mk(0,0,0,0,1,0,0,0,0,0,1,0,0,0,0), 1'b0, 6'($urandom));
    check("count_wrap", 32'(o_instr_count), 32'(saved_cnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
